alu_rr_scheduler: RTL

Round-robin scheduler that shares one `alu_4bit` instance among `N_REQ` requesters. It arbitrates operation requests, latches the granted operands and opcode, and drives the shared ALU. It registers the result, guards divide-by-zero, and returns the result on a single valid/ready response channel tagged with the requester ID. It sits between the requesting datapath blocks and the shared 4-bit ALU; only one operation is in flight at a time.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_4bit.sv | 34 +++
 rtl/rr_arbiter.sv | 34 +++
 rtl/alu_rr_scheduler.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings, scheduler FSM states and divide-by-zero helpers
// for the round-robin ALU scheduler.
package alu_pkg;

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] MUL = 2'b10;
  localparam logic [1:0] DIV = 2'b11;

  localparam logic [3:0] DIV_ZERO_RESULT = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  function automatic logic is_div_zero(input logic [1:0] op, input logic [3:0] b);
    return (op == DIV) && (b == 4'h0);
  endfunction

endpackage

// File: rtl/alu_4bit.sv
// Combinational 4-bit ALU: ADD/SUB/MUL/DIV, all results modulo 16.
// Division by zero yields a defined value so nothing downstream sees X.
module alu_4bit
  import alu_pkg::*;
(
  input  logic [1:0] op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] f
);

  logic [7:0] prod_s;

  assign prod_s = {4'h0, a} * {4'h0, b};

  // Opcode decode into the 4-bit result.
  always_comb begin
    f = 4'h0;
    case (op)
      ADD: f = a + b;
      SUB: f = a - b;
      MUL: f = prod_s[3:0];
      DIV: begin
        if (b == 4'h0) begin
          f = DIV_ZERO_RESULT;
        end else begin
          f = a / b;
        end
      end
      default: f = 4'h0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr,
// wrapping modulo N_REQ. The pointer itself is owned by the caller.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  logic [ID_W-1:0] cand_s;

  // Rotating priority search starting at ptr.
  always_comb begin
    gnt    = {N_REQ{1'b0}};
    idx    = {ID_W{1'b0}};
    any    = 1'b0;
    cand_s = {ID_W{1'b0}};
    for (int k = 0; k < N_REQ; k++) begin
      cand_s = ID_W'((int'(ptr) + k) % N_REQ);
      if (!any && req[cand_s]) begin
        any         = 1'b1;
        gnt[cand_s] = 1'b1;
        idx         = cand_s;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one alu_4bit among N_REQ requesters: round-robin grant in IDLE,
// one execute cycle, then a held valid/ready response tagged with the ID.
module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [2*N_REQ-1:0]   req_op,
  input  logic [4*N_REQ-1:0]   req_a,
  input  logic [4*N_REQ-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [3:0]           rsp_f,
  output logic                 rsp_err,
  output logic                 busy
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

  state_t          state_r;
  logic [ID_W-1:0] ptr_r;
  logic [ID_W-1:0] id_r;
  logic [1:0]      op_r;
  logic [3:0]      a_r;
  logic [3:0]      b_r;
  logic            rsp_valid_r;
  logic [ID_W-1:0] rsp_id_r;
  logic [3:0]      rsp_f_r;
  logic            rsp_err_r;

  logic [N_REQ-1:0] gnt_s;
  logic [ID_W-1:0]  idx_s;
  logic             any_s;
  logic [1:0]       sel_op_s;
  logic [3:0]       sel_a_s;
  logic [3:0]       sel_b_s;
  logic [3:0]       alu_f_s;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req (req_valid),
    .ptr (ptr_r),
    .gnt (gnt_s),
    .idx (idx_s),
    .any (any_s)
  );

  alu_4bit u_alu (
    .op (op_r),
    .a  (a_r),
    .b  (b_r),
    .f  (alu_f_s)
  );

  // Grant-driven payload mux from the packed requester buses.
  always_comb begin
    sel_op_s = 2'b00;
    sel_a_s  = 4'h0;
    sel_b_s  = 4'h0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_s[i]) begin
        sel_op_s = req_op[2*i +: 2];
        sel_a_s  = req_a[4*i +: 4];
        sel_b_s  = req_b[4*i +: 4];
      end else begin
        sel_op_s = sel_op_s;
      end
    end
  end

  // Scheduler FSM with latched operation and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      ptr_r       <= {ID_W{1'b0}};
      id_r        <= {ID_W{1'b0}};
      op_r        <= 2'b00;
      a_r         <= 4'h0;
      b_r         <= 4'h0;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= {ID_W{1'b0}};
      rsp_f_r     <= 4'h0;
      rsp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_s) begin
            op_r    <= sel_op_s;
            a_r     <= sel_a_s;
            b_r     <= sel_b_s;
            id_r    <= idx_s;
            ptr_r   <= (idx_s == LAST_ID) ? {ID_W{1'b0}} : idx_s + 1'b1;
            state_r <= EXEC;
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
          // The divide-by-zero guard overrides the ALU so the flag and value agree.
          if (is_div_zero(op_r, b_r)) begin
            rsp_f_r   <= DIV_ZERO_RESULT;
            rsp_err_r <= 1'b1;
          end else begin
            rsp_f_r   <= alu_f_s;
            rsp_err_r <= 1'b0;
          end
          rsp_id_r    <= id_r;
          rsp_valid_r <= 1'b1;
          state_r     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = (state_r == IDLE) ? gnt_s : {N_REQ{1'b0}};
  assign busy      = (state_r != IDLE);
  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_f     = rsp_f_r;
  assign rsp_err   = rsp_err_r;

endmodule
